// File: rtl/punc_control_pkg.sv
// punc_defs: shared opcode, state and datapath select encodings for the PUnC control unit
package punc_defs;
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT} state_t;
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
  localparam logic [3:0] OP_RSV8 = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'ha, OP_STI = 4'hb;
  localparam logic [3:0] OP_JMP = 4'hc, OP_RSVD = 4'hd, OP_LEA = 4'he, OP_TRAP = 4'hf;
  localparam logic [1:0] MEM_R_ADDR_SEL_PC = 2'd0, MEM_R_ADDR_SEL_PC_OFF = 2'd1;
  localparam logic [1:0] MEM_R_ADDR_SEL_R0_OFF = 2'd2, MEM_R_ADDR_SEL_MDR = 2'd3;
  localparam logic MEM_W_ADDR_SEL_PC_OFF = 1'b0, MEM_W_ADDR_SEL_R1_OFF = 1'b1;
  localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'd0, RF_W_DATA_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_W_DATA_SEL_PC = 2'd2, RF_W_DATA_SEL_PC_OFF = 2'd3;
  localparam logic RF_W_ADDR_SEL_IR = 1'b0, RF_W_ADDR_SEL_R7 = 1'b1;
  localparam logic RF_R0_ADDR_SEL_SR1 = 1'b0, RF_R0_ADDR_SEL_DR = 1'b1;
  localparam logic RF_R1_ADDR_SEL_SR2 = 1'b0, RF_R1_ADDR_SEL_SR1 = 1'b1;
  localparam logic [1:0] PC_LD_DATA_SEL_OFF9 = 2'd0, PC_LD_DATA_SEL_R0 = 2'd1;
  localparam logic [1:0] PC_LD_DATA_SEL_OFF11 = 2'd2;
  localparam logic [1:0] ALU_FN_ADD = 2'd0, ALU_FN_AND = 2'd1, ALU_FN_NOT = 2'd2, ALU_FN_PASS = 2'd3;
  function automatic logic is_reserved(input logic [3:0] op);
    return op == OP_RSV8 || op == OP_RSVD;
  endfunction
endpackage

// File: rtl/punc_control_br_eval.sv
// punc_br_eval: branch taken when any requested nzp flag matches the held condition codes
module punc_br_eval (
  input  logic [2:0] nzp,
  input  logic [2:0] cc,
  output logic       take
);
  assign take = |(nzp & cc);
endmodule

// File: rtl/punc_control.sv
// punc_control: PUnC LC3 fetch/decode/execute sequencer; PUNC_ILLEGAL_OP_TRAP_EN halts on reserved opcodes
module punc_control
  import punc_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  cc,
  output logic        mem_w_en,
  output logic        mem_w_addr_sel,
  output logic [1:0]  mem_r_addr_sel,
  output logic        mdr_ld,
  output logic        rf_w_en,
  output logic        rf_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_r0_addr_sel,
  output logic        rf_r1_addr_sel,
  output logic [1:0]  alu_sel,
  output logic        alu_b_sel,
  output logic        cc_ld,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_ld_data_sel,
`ifdef PUNC_ILLEGAL_OP_TRAP_EN
  output logic        illegal_op,
`endif
  output logic        halted
);
  state_t state;
  logic [3:0] op;
  logic br_take, to_halt;
  logic unused_ir;
  assign op = ir[15:12];
  assign unused_ir = &{1'b0, ir[8:6], ir[4:0]};
`ifdef PUNC_ILLEGAL_OP_TRAP_EN
  logic illegal_q;
  assign to_halt = op == OP_TRAP || is_reserved(op);
  assign illegal_op = state == S_HALT && illegal_q;
  always_ff @(posedge clk)
    if (rst) illegal_q <= 1'b0;
    else if (state == S_DECODE) illegal_q <= is_reserved(op);
`else
  assign to_halt = op == OP_TRAP;
`endif
  punc_br_eval br (.nzp(ir[11:9]), .cc(cc), .take(br_take));
  always_ff @(posedge clk)
    if (rst) state <= S_INIT;
    else
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= to_halt ? S_HALT : S_EXEC;
        S_EXEC:   state <= (op == OP_LDI || op == OP_STI) ? S_EXEC2 : S_FETCH;
        S_EXEC2:  state <= S_FETCH;
        default:  state <= S_HALT;
      endcase
  always_comb begin
    mem_w_en = 1'b0;
    mem_w_addr_sel = MEM_W_ADDR_SEL_PC_OFF;
    mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
    mdr_ld = 1'b0;
    rf_w_en = 1'b0;
    rf_w_addr_sel = RF_W_ADDR_SEL_IR;
    rf_w_data_sel = RF_W_DATA_SEL_ALU;
    rf_r0_addr_sel = RF_R0_ADDR_SEL_SR1;
    rf_r1_addr_sel = RF_R1_ADDR_SEL_SR2;
    alu_sel = ALU_FN_ADD;
    alu_b_sel = 1'b0;
    cc_ld = 1'b0;
    ir_ld = 1'b0;
    pc_ld = 1'b0;
    pc_clr = 1'b0;
    pc_inc = 1'b0;
    pc_ld_data_sel = PC_LD_DATA_SEL_OFF9;
    halted = 1'b0;
    case (state)
      S_INIT: pc_clr = 1'b1;
      S_FETCH: begin
        ir_ld = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXEC:
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_w_en = 1'b1;
            cc_ld = 1'b1;
            alu_sel = op == OP_NOT ? ALU_FN_NOT : op == OP_AND ? ALU_FN_AND : ALU_FN_ADD;
            alu_b_sel = op != OP_NOT && ir[5];
          end
          OP_BR: pc_ld = br_take;
          OP_JMP: begin
            pc_ld = 1'b1;
            pc_ld_data_sel = PC_LD_DATA_SEL_R0;
          end
          OP_JSR: begin
            rf_w_en = 1'b1;
            rf_w_addr_sel = RF_W_ADDR_SEL_R7;
            rf_w_data_sel = RF_W_DATA_SEL_PC;
            pc_ld = 1'b1;
            pc_ld_data_sel = ir[11] ? PC_LD_DATA_SEL_OFF11 : PC_LD_DATA_SEL_R0;
          end
          OP_LD, OP_LDR: begin
            mem_r_addr_sel = op == OP_LD ? MEM_R_ADDR_SEL_PC_OFF : MEM_R_ADDR_SEL_R0_OFF;
            rf_w_en = 1'b1;
            rf_w_data_sel = RF_W_DATA_SEL_MEM;
            cc_ld = 1'b1;
          end
          OP_LEA: begin
            rf_w_en = 1'b1;
            rf_w_data_sel = RF_W_DATA_SEL_PC_OFF;
          end
          OP_ST, OP_STR: begin
            mem_w_en = 1'b1;
            mem_w_addr_sel = op == OP_STR ? MEM_W_ADDR_SEL_R1_OFF : MEM_W_ADDR_SEL_PC_OFF;
            rf_r1_addr_sel = op == OP_STR ? RF_R1_ADDR_SEL_SR1 : RF_R1_ADDR_SEL_SR2;
            rf_r0_addr_sel = RF_R0_ADDR_SEL_DR;
          end
          OP_LDI, OP_STI: begin
            mem_r_addr_sel = MEM_R_ADDR_SEL_PC_OFF;
            mdr_ld = 1'b1;
          end
          default: ;
        endcase
      S_EXEC2:
        if (op == OP_LDI) begin
          mem_r_addr_sel = MEM_R_ADDR_SEL_MDR;
          rf_w_en = 1'b1;
          rf_w_data_sel = RF_W_DATA_SEL_MEM;
          cc_ld = 1'b1;
        end else begin
          mem_w_en = 1'b1;
          rf_r0_addr_sel = RF_R0_ADDR_SEL_DR;
        end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    // a reset cycle must never commit architectural state
    if (rst) begin
      rf_w_en = 1'b0;
      mem_w_en = 1'b0;
      pc_ld = 1'b0;
    end
  end
endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control: directed instruction vectors against hand-derived control strobes
module tb_punc_control;
  typedef struct packed {
    logic       mem_w_en;
    logic       mem_w_addr_sel;
    logic [1:0] mem_r_addr_sel;
    logic       mdr_ld;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] alu_sel;
    logic       alu_b_sel;
    logic       cc_ld;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic       halted;
  } outs_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] ir = '0;
  logic [2:0] cc = '0;
  outs_t o;
  int vectors = 0, misses = 0;
  localparam outs_t QUIET = '0;
  localparam outs_t E_INIT = '{pc_clr: 1'b1, default: '0};
  localparam outs_t E_FETCH = '{ir_ld: 1'b1, pc_inc: 1'b1, default: '0};
  localparam outs_t E_HALT = '{halted: 1'b1, default: '0};
  localparam outs_t E_LDI2 = '{mem_r_addr_sel: 2'd3, rf_w_en: 1'b1, rf_w_data_sel: 2'd1, cc_ld: 1'b1, default: '0};
`ifdef PUNC_ILLEGAL_OP_TRAP_EN
  logic illegal_op;
`endif
  always #5 clk = ~clk;
  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .cc(cc),
    .mem_w_en(o.mem_w_en), .mem_w_addr_sel(o.mem_w_addr_sel), .mem_r_addr_sel(o.mem_r_addr_sel),
    .mdr_ld(o.mdr_ld), .rf_w_en(o.rf_w_en), .rf_w_addr_sel(o.rf_w_addr_sel),
    .rf_w_data_sel(o.rf_w_data_sel), .rf_r0_addr_sel(o.rf_r0_addr_sel), .rf_r1_addr_sel(o.rf_r1_addr_sel),
    .alu_sel(o.alu_sel), .alu_b_sel(o.alu_b_sel), .cc_ld(o.cc_ld), .ir_ld(o.ir_ld), .pc_ld(o.pc_ld),
    .pc_clr(o.pc_clr), .pc_inc(o.pc_inc), .pc_ld_data_sel(o.pc_ld_data_sel),
`ifdef PUNC_ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .halted(o.halted)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [15:0] ir_v, input logic [2:0] cc_v,
                     input outs_t e1, input outs_t e2, input bit two);
    ir = ir_v;
    cc = cc_v;
    step();
    chk({tag, "_decode"}, 32'(o), 32'(QUIET));
    step();
    chk({tag, "_exec"}, 32'(o), 32'(e1));
    if (two) begin
      step();
      chk({tag, "_exec2"}, 32'(o), 32'(e2));
    end
    step();
    chk({tag, "_fetch"}, 32'(o), 32'(E_FETCH));
  endtask
  initial begin
    step();
    chk("reset_init", 32'(o), 32'(E_INIT));
    rst = 1'b0;
    step();
    chk("first_fetch", 32'(o), 32'(E_FETCH));
    run("add_imm", 16'h12A3, 3'b000, '{rf_w_en: 1'b1, cc_ld: 1'b1, alu_b_sel: 1'b1, default: '0}, QUIET, 0);
    run("and_reg", 16'h5283, 3'b000, '{rf_w_en: 1'b1, cc_ld: 1'b1, alu_sel: 2'd1, default: '0}, QUIET, 0);
    run("not", 16'h927F, 3'b000, '{rf_w_en: 1'b1, cc_ld: 1'b1, alu_sel: 2'd2, default: '0}, QUIET, 0);
    run("brz_taken", 16'h0404, 3'b010, '{pc_ld: 1'b1, default: '0}, QUIET, 0);
    run("brz_not", 16'h0404, 3'b100, QUIET, QUIET, 0);
    run("jmp", 16'hC1C0, 3'b001, '{pc_ld: 1'b1, pc_ld_data_sel: 2'd1, default: '0}, QUIET, 0);
    run("jsr", 16'h4810, 3'b000, '{rf_w_en: 1'b1, rf_w_addr_sel: 1'b1, rf_w_data_sel: 2'd2, pc_ld: 1'b1,
        pc_ld_data_sel: 2'd2, default: '0}, QUIET, 0);
    run("jsrr", 16'h4080, 3'b000, '{rf_w_en: 1'b1, rf_w_addr_sel: 1'b1, rf_w_data_sel: 2'd2, pc_ld: 1'b1,
        pc_ld_data_sel: 2'd1, default: '0}, QUIET, 0);
    run("ld", 16'h2405, 3'b000, '{mem_r_addr_sel: 2'd1, rf_w_en: 1'b1, rf_w_data_sel: 2'd1, cc_ld: 1'b1,
        default: '0}, QUIET, 0);
    run("ldr", 16'h6485, 3'b000, '{mem_r_addr_sel: 2'd2, rf_w_en: 1'b1, rf_w_data_sel: 2'd1, cc_ld: 1'b1,
        default: '0}, QUIET, 0);
    run("lea", 16'hE603, 3'b000, '{rf_w_en: 1'b1, rf_w_data_sel: 2'd3, default: '0}, QUIET, 0);
    run("st", 16'h3602, 3'b000, '{mem_w_en: 1'b1, rf_r0_addr_sel: 1'b1, default: '0}, QUIET, 0);
    run("str", 16'h7285, 3'b000, '{mem_w_en: 1'b1, mem_w_addr_sel: 1'b1, rf_r1_addr_sel: 1'b1,
        rf_r0_addr_sel: 1'b1, default: '0}, QUIET, 0);
    run("ldi", 16'hA605, 3'b000, '{mem_r_addr_sel: 2'd1, mdr_ld: 1'b1, default: '0}, E_LDI2, 1);
    run("sti", 16'hB605, 3'b000, '{mem_r_addr_sel: 2'd1, mdr_ld: 1'b1, default: '0},
        '{mem_w_en: 1'b1, rf_r0_addr_sel: 1'b1, default: '0}, 1);
`ifndef PUNC_ILLEGAL_OP_TRAP_EN
    run("nop8", 16'h8000, 3'b111, QUIET, QUIET, 0);
    run("nopd", 16'hD000, 3'b111, QUIET, QUIET, 0);
`endif
    ir = 16'hF025;
    step();
    chk("trap_decode", 32'(o), 32'(QUIET));
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", 32'(o), 32'(E_HALT));
    end
    rst = 1'b1;
    #1;
    chk("halt_rst_same", 32'(o), 32'(E_HALT));
    step();
    chk("halt_rst_init", 32'(o), 32'(E_INIT));
    rst = 1'b0;
    step();
    chk("refetch", 32'(o), 32'(E_FETCH));
    ir = 16'hA605;
    step();
    step();
    step();
    chk("ldi_exec2", 32'(o), 32'(E_LDI2));
    rst = 1'b1;
    #1;
    chk("exec2_rst_wen", 32'(o.rf_w_en), 32'd0);
    step();
    chk("exec2_rst_init", 32'(o), 32'(E_INIT));
    chk("init_rf_w_en", 32'(o.rf_w_en), 32'd0);
    rst = 1'b0;
    step();
    chk("final_fetch", 32'(o), 32'(E_FETCH));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control unit for the PUnC LC3 processor; the counterpart of the PUnC datapath.
- Consumes the instruction register and condition codes from the datapath.
- Sequences fetch/decode/execute.
- Drives every datapath select, load and write-enable strobe.
- Outputs are decoded combinationally from the current state and the IR (Moore on state, qualified by opcode).

Parameters:
- none (encodings fixed in shared package)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ir  in  16  instruction register contents from datapath
- cc  in  3  condition codes {n,z,p} held in datapath
- mem_w_en  out  1  memory write strobe
- mem_w_addr_sel  out  1  0: pc+sext9; 1: rf_r1+sext6
- mem_r_addr_sel  out  2  0: pc; 1: pc+sext9; 2: rf_r0+sext6; 3: mdr
- mdr_ld  out  1  latch mem_r_data into datapath MDR (indirect ops)
- rf_w_en  out  1  register file write strobe
- rf_w_addr_sel  out  1  0: ir[11:9]; 1: R7
- rf_w_data_sel  out  2  0: ALU; 1: mem_r_data; 2: pc; 3: pc+sext9
- rf_r0_addr_sel  out  1  0: ir[8:6]; 1: ir[11:9]
- rf_r1_addr_sel  out  1  0: ir[2:0]; 1: ir[8:6]
- alu_sel  out  2  0: ADD; 1: AND; 2: NOT; 3: PASS
- alu_b_sel  out  1  0: rf_r1; 1: sext5
- cc_ld  out  1  update datapath cc from rf_w_data
- ir_ld  out  1  load IR from mem_r_data
- pc_ld  out  1  load PC from pc_ld_data
- pc_clr  out  1  clear PC
- pc_inc  out  1  PC += 1
- pc_ld_data_sel  out  2  0: pc+sext9; 1: rf_r0; 2: pc+sext11
- halted  out  1  processor stopped

Behaviour:
- States: INIT, FETCH, DECODE, EXEC, EXEC2, HALT.
- Reset: rst is synchronous and active-high, clocked on clk. rst=1 forces the next state to INIT regardless of the current state, including mid-EXEC2 and in HALT.
- Default outputs: every output is 0 unless listed below.
- INIT: pc_clr=1. Next state FETCH.
- FETCH: mem_r_addr_sel=0, ir_ld=1, pc_inc=1. Next state DECODE.
- DECODE: no strobes. Next state HALT if opcode=1111 (any TRAP), else EXEC.
- EXEC, by opcode ir[15:12]:
  - ADD 0001 / AND 0101: rf_w_en, cc_ld, alu_sel ADD/AND, alu_b_sel=ir[5].
  - NOT 1001: rf_w_en, cc_ld, alu_sel=2.
  - BR 0000: pc_ld=1 with sel 0 iff (ir[11:9] & cc) != 0.
  - JMP 1100: pc_ld, sel 1.
  - JSR 0100: rf_w_en, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld. pc_ld_data_sel=2 if ir[11], else 1. The R7 write uses the old incremented pc.
  - LD 0010: mem_r_addr_sel=1, rf_w_en, data 1, cc_ld.
  - LDR 0110: mem_r_addr_sel=2, rf_w_en, data 1, cc_ld.
  - LEA 1110: rf_w_en, data 3; no cc_ld.
  - ST 0011: mem_w_en, mem_w_addr_sel=0, rf_r0_addr_sel=1.
  - STR 0111: mem_w_en, mem_w_addr_sel=1, rf_r1_addr_sel=1, rf_r0_addr_sel=1.
  - LDI 1010 / STI 1011: mem_r_addr_sel=1, mdr_ld=1.
  - 1000 and 1101: no strobes (NOP).
- Next state after EXEC: EXEC2 for LDI/STI, else FETCH.
- EXEC2:
  - LDI: mem_r_addr_sel=3, rf_w_en, data 1, cc_ld.
  - STI: mem_w_en with address = mdr (mem_w_addr from mdr when mdr_ld path active), rf_r0_addr_sel=1.
  - Next state FETCH.
- HALT: halted=1, no other strobes. Stays in HALT until rst.
- Latency: 3 cycles per instruction; LDI/STI take 4.
- Write strobes: rf_w_en, mem_w_en and pc_ld are never asserted in the same cycle as rst=1.

Optional Feature:
- Macro: PUNC_ILLEGAL_OP_TRAP_EN.
- Defined: opcodes 1000 and 1101 go DECODE->HALT with halted=1, and the extra output illegal_op (1 bit) is 1 while in HALT due to such an opcode.
- Undefined: those opcodes execute as NOP, and the illegal_op port is absent.

Decomposition:
- Package punc_defs holds:
  - opcode constants
  - state enum
  - all select encodings: MEM_R_ADDR_SEL_*, MEM_W_ADDR_SEL_*, RF_W_DATA_SEL_*, RF_W_ADDR_SEL_*, RF_R0/R1_ADDR_SEL_*, PC_LD_DATA_SEL_*, ALU_FN_*
- One sub-module is natural: punc_br_eval, the combinational nzp-versus-cc branch decision.
- The FSM and output decode stay in punc_control.

Test Plan:
- rst pulse -> INIT with pc_clr=1 one cycle, then FETCH with ir_ld=1, pc_inc=1, mem_r_addr_sel=0.
- ir=0x12A3 (ADD R1,R2,#3) -> EXEC: rf_w_en=1, alu_sel=0, alu_b_sel=1, cc_ld=1, rf_w_addr_sel=0; back to FETCH after 3 cycles total.
- ir=0x0404 (BRz +4), cc=010 -> EXEC: pc_ld=1, pc_ld_data_sel=0. Same with cc=100 -> pc_ld=0.
- ir=0xA605 (LDI R3) -> EXEC: mem_r_addr_sel=1, mdr_ld=1; EXEC2: mem_r_addr_sel=3, rf_w_en=1, rf_w_data_sel=1, cc_ld=1; 4 cycles total.
- ir=0x4810 (JSR +16) -> EXEC: rf_w_en=1, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld=1, pc_ld_data_sel=2.
- ir=0xF025 -> HALT with halted=1 held for 20 cycles, no strobes. rst=1 during HALT, and separately mid-EXEC2 of LDI, -> next cycle INIT, rf_w_en=0.
